// File: rtl/ultrasonic_trig_seq.sv
// Periodic HC-SR04 trigger sequencer with echo supervision (missing / stuck echo) on the 1 MHz clock.
// trig/busy/status are registered; a stuck-high echo holds the sequencer in HOLDOFF until echo drops.
module ultrasonic_trig_seq #(
  parameter int TRIG_US     = 10,
  parameter int PERIOD_US   = 60000,
  parameter int RISE_TMO_US = 30000,
  parameter int ECHO_MAX_US = 25000
) (
  input  logic       clk_1m,
  input  logic       rst,
  input  logic       enable,
  input  logic       echo,
  output logic       trig,
  output logic       busy,
  output logic       meas_done,
  output logic       no_echo,
  output logic       echo_stuck,
  output logic [7:0] fault_cnt
);

  typedef enum logic [2:0] {IDLE, TRIG, WAIT_RISE, WAIT_FALL, HOLDOFF} state_t;

  localparam logic [15:0] TRIG_LAST   = 16'(TRIG_US - 1);
  localparam logic [15:0] PERIOD_LAST = 16'(PERIOD_US - 1);
  localparam logic [15:0] RISE_LAST   = 16'(RISE_TMO_US - 1);
  localparam logic [15:0] ECHO_LAST   = 16'(ECHO_MAX_US - 1);

  state_t      state, state_nxt;
  logic        echo_s1, echo_s2;
  logic        rise, fall;
  logic [15:0] period_cnt, phase_cnt;
  logic        nr, st, nr_nxt, st_nxt;
  logic        complete;

  assign rise = echo_s1 & ~echo_s2;
  assign fall = ~echo_s1 & echo_s2;

  always_comb begin
    state_nxt = state;
    nr_nxt    = nr;
    st_nxt    = st;
    complete  = 1'b0;
    case (state)
      IDLE:      if (enable) state_nxt = TRIG;
      TRIG:      if (phase_cnt == TRIG_LAST) state_nxt = WAIT_RISE;
      WAIT_RISE: begin
        // an echo already high on entry never produces a rise, so it times out here
        if (rise) begin
          state_nxt = WAIT_FALL;
        end else if (phase_cnt == RISE_LAST) begin
          nr_nxt    = 1'b1;
          state_nxt = HOLDOFF;
        end
      end
      WAIT_FALL: begin
        if (fall) begin
          state_nxt = HOLDOFF;
        end else if (phase_cnt == ECHO_LAST) begin
          st_nxt    = 1'b1;
          state_nxt = HOLDOFF;
        end
      end
      HOLDOFF: begin
        if (period_cnt == PERIOD_LAST && !echo_s2) begin
          complete  = 1'b1;
          nr_nxt    = 1'b0;
          st_nxt    = 1'b0;
          state_nxt = enable ? TRIG : IDLE;
        end
      end
      default:   state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_1m or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      echo_s1    <= 1'b0;
      echo_s2    <= 1'b0;
      period_cnt <= '0;
      phase_cnt  <= '0;
      nr         <= 1'b0;
      st         <= 1'b0;
      trig       <= 1'b0;
      busy       <= 1'b0;
      meas_done  <= 1'b0;
      no_echo    <= 1'b0;
      echo_stuck <= 1'b0;
      fault_cnt  <= '0;
    end else begin
      echo_s1   <= echo;
      echo_s2   <= echo_s1;
      state     <= state_nxt;
      nr        <= nr_nxt;
      st        <= st_nxt;
      trig      <= (state_nxt == TRIG);
      busy      <= (state_nxt != IDLE);
      meas_done <= complete;

      if (state_nxt != state)
        phase_cnt <= '0;
      else if (phase_cnt != 16'hFFFF)
        phase_cnt <= phase_cnt + 16'd1;

      // trigger spacing comes from this counter reaching PERIOD_LAST before completion
      if (state_nxt == TRIG && state != TRIG)
        period_cnt <= '0;
      else if (state != IDLE && period_cnt != PERIOD_LAST)
        period_cnt <= period_cnt + 16'd1;

      if (complete) begin
        no_echo    <= nr;
        echo_stuck <= st;
        if ((nr | st) && fault_cnt != 8'hFF)
          fault_cnt <= fault_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_ultrasonic_trig_seq.sv
// Bench for ultrasonic_trig_seq: directed and randomized echo patterns against an arithmetic timing model.
module tb_ultrasonic_trig_seq;

  localparam int TRIG_US     = 10;
  localparam int PERIOD_US   = 150;
  localparam int RISE_TMO_US = 60;
  localparam int ECHO_MAX_US = 50;

  logic       clk_1m = 1'b0;
  logic       rst    = 1'b1;
  logic       enable = 1'b0;
  logic       echo   = 1'b0;
  logic       trig, busy, meas_done, no_echo, echo_stuck;
  logic [7:0] fault_cnt;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int fcnt_m = 0;

  ultrasonic_trig_seq #(
    .TRIG_US(TRIG_US), .PERIOD_US(PERIOD_US),
    .RISE_TMO_US(RISE_TMO_US), .ECHO_MAX_US(ECHO_MAX_US)
  ) dut (
    .clk_1m(clk_1m), .rst(rst), .enable(enable), .echo(echo),
    .trig(trig), .busy(busy), .meas_done(meas_done),
    .no_echo(no_echo), .echo_stuck(echo_stuck), .fault_cnt(fault_cnt)
  );

  initial forever #5 clk_1m = ~clk_1m;

  task automatic check(input string tag, input int obs, input int exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk_1m);
    cyc++;
  endtask

  // Entered on the first sample with trig high. d = echo start after trig falls
  // (negative: echo never rises), w = echo high time, en_drop drops enable mid-echo.
  task automatic measure(input int d, input int w, input bit en_drop);
    int n_r, n0, cnt, exp_done;
    bit nr, st, trig_bad, busy_bad, dbl_done, done_seen;
    n_r = cyc;
    check("trig_rise", trig, 1);
    cnt = 0;
    dbl_done = 1'b0;
    while (trig && cnt < 4 * TRIG_US) begin
      if (cnt > 0 && meas_done) dbl_done = 1'b1;
      cnt++;
      tick();
    end
    check("trig_width", cnt, TRIG_US);
    check("done_pulse_1cyc", dbl_done, 0);
    n0 = cyc;

    nr = (d < 0) || (d > RISE_TMO_US - 2);
    st = !nr && (w > ECHO_MAX_US);
    exp_done = n_r + PERIOD_US;
    if (d >= 0 && n0 + d + w + 3 > exp_done) exp_done = n0 + d + w + 3;

    trig_bad = 1'b0;
    busy_bad = 1'b0;
    done_seen = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      if (d >= 0 && k == d) echo = 1'b1;
      if (d >= 0 && k == d + w) echo = 1'b0;
      if (en_drop && d >= 0 && k == d + 5) enable = 1'b0;
      if (meas_done) begin
        done_seen = 1'b1;
        break;
      end
      if (trig) trig_bad = 1'b1;
      if (!busy) busy_bad = 1'b1;
      tick();
    end
    check("meas_done_seen", done_seen, 1);
    check("meas_done_time", cyc, exp_done);
    check("no_trig_while_busy", trig_bad, 0);
    check("busy_held", busy_bad, 0);

    if (nr || st) fcnt_m = (fcnt_m < 255) ? fcnt_m + 1 : 255;
    check("no_echo", no_echo, nr);
    check("echo_stuck", echo_stuck, st);
    check("fault_cnt", fault_cnt, fcnt_m);

    if (!en_drop) begin
      check("retrig_at_done", trig, 1);
    end else begin
      check("idle_trig_low", trig, 0);
      check("idle_busy_low", busy, 0);
      trig_bad = 1'b0;
      repeat (4) begin
        tick();
        if (trig || busy) trig_bad = 1'b1;
      end
      check("idle_hold", trig_bad, 0);
      enable = 1'b1;
      tick();
      check("reenable_trig", trig, 1);
    end
  endtask

  initial begin
    int mode;
    tick();
    tick();
    check("rst_trig", trig, 0);
    check("rst_busy", busy, 0);
    check("rst_meas_done", meas_done, 0);
    check("rst_no_echo", no_echo, 0);
    check("rst_echo_stuck", echo_stuck, 0);
    check("rst_fault_cnt", fault_cnt, 0);
    rst = 1'b0;
    enable = 1'b1;
    tick();

    // normal cycles with random echo placement
    repeat (3) measure($urandom_range(0, RISE_TMO_US - 2), $urandom_range(1, ECHO_MAX_US), 1'b0);
    // missing echo
    measure(-1, 0, 1'b0);
    measure(-1, 0, 1'b0);
    // rise timeout and echo-length boundaries
    measure(RISE_TMO_US - 2, 5, 1'b0);
    measure(RISE_TMO_US - 1, 5, 1'b0);
    measure(3, ECHO_MAX_US, 1'b0);
    measure(3, ECHO_MAX_US + 1, 1'b0);
    // echo stuck well beyond the trigger period
    measure(5, PERIOD_US + 40, 1'b0);
    measure(2, 10, 1'b0);
    // enable dropped during WAIT_FALL
    measure(10, 30, 1'b1);
    // random mix
    repeat (6) begin
      mode = $urandom_range(0, 2);
      if (mode == 0)
        measure($urandom_range(0, RISE_TMO_US - 2), $urandom_range(1, ECHO_MAX_US), 1'b0);
      else if (mode == 1)
        measure(-1, 0, 1'b0);
      else
        measure($urandom_range(0, RISE_TMO_US - 2), $urandom_range(ECHO_MAX_US + 1, ECHO_MAX_US + 120), 1'b0);
    end

    // reset on the 5th trig cycle
    repeat (4) tick();
    check("pre_rst_trig", trig, 1);
    rst = 1'b1;
    #1;
    check("mid_rst_trig", trig, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_meas_done", meas_done, 0);
    check("mid_rst_no_echo", no_echo, 0);
    check("mid_rst_echo_stuck", echo_stuck, 0);
    check("mid_rst_fault_cnt", fault_cnt, 0);
    fcnt_m = 0;
    tick();
    tick();
    rst = 1'b0;
    tick();
    measure($urandom_range(0, RISE_TMO_US - 2), $urandom_range(1, ECHO_MAX_US), 1'b0);

    // fault counter saturation
    repeat (260) measure(-1, 0, 1'b0);
    check("fault_sat", fault_cnt, 255);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
